// File: rtl/audio_uart_framer.sv
// audio_uart_framer: buffers the upper 16 bits of incoming audio samples in
// a small FIFO and serialises them for a one-byte UART transmitter. The byte
// stream is framed as a sync byte followed by FRAME_LEN {hi, lo} byte pairs.
module audio_uart_framer #(
  parameter int          SAMPLE_WIDTH = 24,
  parameter int          FIFO_DEPTH   = 8,
  parameter int          FRAME_LEN    = 16,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic                           enable_in,
  input  logic signed [SAMPLE_WIDTH-1:0] sample_in,
  input  logic                           valid_in,
  input  logic                           tx_busy_in,
  output logic [7:0]                     byte_out,
  output logic                           byte_trigger_out,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_count_out,
  output logic                           overflow_out
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;
  localparam int FC_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  typedef enum logic [2:0] {
    IDLE, SEND_SYNC, SEND_HI, SEND_LO, WAIT_BUSY, WAIT_IDLE
  } state_t;

  // Where WAIT_IDLE goes once the transmitter has finished the current byte.
  typedef enum logic [1:0] {RET_LOAD, RET_LO, RET_IDLE} ret_t;

  // Keeps the upper 16 bits of a sample; lower bits are dropped, no rounding.
  function automatic logic signed [15:0] trunc16(input logic signed [SAMPLE_WIDTH-1:0] s);
    return 16'(s >>> (SAMPLE_WIDTH - 16));
  endfunction

  logic [15:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [15:0]     held;
  state_t          state;
  ret_t            ret;
  logic [FC_W-1:0] frame_cnt;

  logic full;
  logic empty;
  logic pop_idle;
  logic pop_load;
  logic pop;
  logic push;

  assign full  = (count == CW'(FIFO_DEPTH));
  assign empty = (count == '0);

  // A sample leaves the FIFO only at the start of its byte pair: either
  // straight from IDLE mid-frame, or right after the sync byte completes.
  assign pop_idle = (state == IDLE) && !empty && !tx_busy_in && (frame_cnt != '0);
  assign pop_load = (state == WAIT_IDLE) && !tx_busy_in && (ret == RET_LOAD);
  assign pop      = pop_idle || pop_load;

  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign push = valid_in && enable_in && (!full || pop);

  assign fifo_count_out = count;

  // FIFO pointers, occupancy count and sticky overflow flag.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow_out <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (valid_in && enable_in && full && !pop) overflow_out <= 1'b1;
    end
  end

  // Sample storage and the holding register for the pair being sent.
  always_ff @(posedge clk_in) begin
    if (push) mem[wr_ptr] <= trunc16(sample_in);
    if (pop)  held <= mem[rd_ptr];
  end

  // Byte sequencer: sync / hi / lo with a busy handshake after each byte.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state            <= IDLE;
      ret              <= RET_IDLE;
      frame_cnt        <= '0;
      byte_out         <= 8'h00;
      byte_trigger_out <= 1'b0;
    end else begin
      byte_trigger_out <= 1'b0;
      case (state)
        IDLE: begin
          if (!empty && !tx_busy_in) begin
            state <= (frame_cnt == '0) ? SEND_SYNC : SEND_HI;
          end
        end
        SEND_SYNC: begin
          if (!tx_busy_in) begin
            byte_out         <= SYNC_BYTE;
            byte_trigger_out <= 1'b1;
            ret              <= RET_LOAD;
            state            <= WAIT_BUSY;
          end
        end
        SEND_HI: begin
          if (!tx_busy_in) begin
            byte_out         <= held[15:8];
            byte_trigger_out <= 1'b1;
            ret              <= RET_LO;
            state            <= WAIT_BUSY;
          end
        end
        SEND_LO: begin
          if (!tx_busy_in) begin
            byte_out         <= held[7:0];
            byte_trigger_out <= 1'b1;
            ret              <= RET_IDLE;
            state            <= WAIT_BUSY;
            if (frame_cnt == FC_W'(FRAME_LEN - 1)) frame_cnt <= '0;
            else                                   frame_cnt <= frame_cnt + 1'b1;
          end
        end
        WAIT_BUSY: begin
          if (tx_busy_in) state <= WAIT_IDLE;
        end
        WAIT_IDLE: begin
          if (!tx_busy_in) begin
            case (ret)
              RET_LOAD: state <= SEND_HI;
              RET_LO:   state <= SEND_LO;
              default:  state <= IDLE;
            endcase
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_uart_framer.sv
// Bench for audio_uart_framer: table of single-sample truncation vectors,
// directed multi-cycle scenarios and a randomized run against a queue model.
module tb_audio_uart_framer;

  localparam int         SW    = 24;
  localparam int         DEPTH = 8;
  localparam int         FLEN  = 16;
  localparam logic [7:0] SYNC  = 8'hA5;

  logic                   clk;
  logic                   rst;
  logic                   enable;
  logic                   valid;
  logic                   tx_busy;
  logic                   trig;
  logic                   ovf;
  logic signed [SW-1:0]   sample;
  logic [7:0]             bout;
  logic [$clog2(DEPTH):0] cnt;

  audio_uart_framer #(
    .SAMPLE_WIDTH(SW), .FIFO_DEPTH(DEPTH), .FRAME_LEN(FLEN), .SYNC_BYTE(SYNC)
  ) dut (
    .clk_in(clk), .rst_in(rst), .enable_in(enable), .sample_in(sample),
    .valid_in(valid), .tx_busy_in(tx_busy), .byte_out(bout),
    .byte_trigger_out(trig), .fifo_count_out(cnt), .overflow_out(ovf)
  );

  typedef struct {
    logic [SW-1:0] smp;
    logic [7:0]    hi;
    logic [7:0]    lo;
  } vec_t;

  vec_t       tbl [6];
  int         errors;
  int         checks;
  logic [7:0] got   [$];
  logic [7:0] exp_q [$];
  int         mfi;
  int         mon_viol  = 0;
  logic       busy_m    = 1'b0;
  logic       start_m   = 1'b0;
  logic       prev_trig = 1'b0;
  int         busy_cnt  = 0;
  logic       hold_busy;
  bit         rand_mode;
  int         base;
  int         pushed;
  int         started;

  assign tx_busy = busy_m | hold_busy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Ideal one-byte transmitter plus trigger-rule monitor.
  always @(negedge clk) begin
    if (trig && (tx_busy || prev_trig)) mon_viol++;
    prev_trig = trig;
    if (start_m) begin
      busy_m   = 1'b1;
      busy_cnt = rand_mode ? int'($urandom_range(1, 6)) : 100;
      start_m  = 1'b0;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) busy_m = 1'b0;
    end
    if (trig) begin
      got.push_back(bout);
      start_m = 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: each accepted sample contributes its upper 16 bits as
  // hi/lo bytes, preceded by a sync byte at the start of every frame.
  task automatic model_push(input logic [SW-1:0] s);
    logic [15:0] v;
    v = 16'(s >> (SW - 16));
    if (mfi % FLEN == 0) exp_q.push_back(SYNC);
    exp_q.push_back(v[15:8]);
    exp_q.push_back(v[7:0]);
    mfi++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; valid = 1'b0; hold_busy = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    mfi = 0;
    exp_q.delete();
  endtask

  task automatic push(input logic [SW-1:0] s);
    @(negedge clk);
    sample = s; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_bytes(input int target, input int budget);
    int n;
    n = 0;
    while (got.size() < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("bytes_arrived", 32'(got.size() >= target), 32'd1);
  endtask

  task automatic expect_stream(input int b, input int budget);
    wait_bytes(b + exp_q.size(), budget);
    settle(150);
    check("stream_len", 32'(got.size() - b), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size(); k++)
      check($sformatf("stream_byte%0d", k), 32'(got[b + k]), 32'(exp_q[k]));
    check("count_drained", 32'(cnt), 32'd0);
    check("trig_rules", 32'(mon_viol), 32'd0);
  endtask

  initial begin
    errors = 0; checks = 0; mfi = 0;
    rst = 1'b0; enable = 1'b1; valid = 1'b0; sample = '0;
    hold_busy = 1'b0; rand_mode = 1'b0;

    tbl[0] = '{24'h123456, 8'h12, 8'h34};
    tbl[1] = '{24'hFFFFFF, 8'hFF, 8'hFF};
    tbl[2] = '{24'h800000, 8'h80, 8'h00};
    tbl[3] = '{24'h7FFFFF, 8'h7F, 8'hFF};
    tbl[4] = '{24'h0000FF, 8'h00, 8'h00};
    tbl[5] = '{24'h01FF80, 8'h01, 8'hFF};

    // Single sample after reset: sync, hi, lo, then FIFO empty again.
    for (int i = 0; i < 6; i++) begin
      do_reset();
      base = got.size();
      push(tbl[i].smp);
      wait_bytes(base + 3, 800);
      settle(150);
      check($sformatf("tbl%0d_sync", i), 32'(got[base]), 32'(SYNC));
      check($sformatf("tbl%0d_hi", i), 32'(got[base + 1]), 32'(tbl[i].hi));
      check($sformatf("tbl%0d_lo", i), 32'(got[base + 2]), 32'(tbl[i].lo));
      check($sformatf("tbl%0d_len", i), 32'(got.size() - base), 32'd3);
      check($sformatf("tbl%0d_cnt", i), 32'(cnt), 32'd0);
    end

    // 17 samples: full frame then a new frame with its own sync byte.
    do_reset();
    base = got.size();
    for (int k = 1; k <= 17; k++) begin
      for (int n = 0; n < 2000 && cnt >= DEPTH; n++) @(negedge clk);
      push(24'(k * 24'h000100));
      model_push(24'(k * 24'h000100));
    end
    expect_stream(base, 8000);
    check("frame2_sync", 32'(got[base + 33]), 32'hA5);
    check("frame2_hi", 32'(got[base + 34]), 32'h00);
    check("frame2_lo", 32'(got[base + 35]), 32'h11);

    // Transmitter stuck busy: 10 pushes into 8 slots.
    do_reset();
    hold_busy = 1'b1;
    base = got.size();
    for (int k = 0; k < 10; k++) begin
      push(24'((k + 1) * 24'h012300));
      if (k < 8) model_push(24'((k + 1) * 24'h012300));
    end
    check("ovf_count", 32'(cnt), 32'd8);
    check("ovf_flag", 32'(ovf), 32'd1);
    hold_busy = 1'b0;
    expect_stream(base, 3000);
    check("ovf_sticky", 32'(ovf), 32'd1);
    do_reset();
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_cnt", 32'(cnt), 32'd0);
    check("rst_trig", 32'(trig), 32'd0);
    check("rst_byte", 32'(bout), 32'd0);

    // Full FIFO: push accepted in the same cycle as the IDLE pop.
    do_reset();
    base = got.size();
    push(24'h0AAA00);
    model_push(24'h0AAA00);
    expect_stream(base, 1000);
    hold_busy = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      push(24'(k * 24'h010203));
      model_push(24'(k * 24'h010203));
    end
    check("full_cnt", 32'(cnt), 32'd8);
    check("full_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    hold_busy = 1'b0; sample = 24'h0F0F00; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    model_push(24'h0F0F00);
    check("pushpop_cnt", 32'(cnt), 32'd8);
    check("pushpop_ovf", 32'(ovf), 32'd0);
    expect_stream(base, 3000);

    // Reset between hi and lo bytes takes effect without a clock edge.
    do_reset();
    base = got.size();
    push(24'hABCDEF);
    push(24'h111111);
    wait_bytes(base + 2, 600);
    settle(5);
    check("mid_byte_pre", 32'(bout), 32'hAB);
    check("mid_cnt_pre", 32'(cnt), 32'd1);
    rst = 1'b1;
    #1;
    check("async_trig", 32'(trig), 32'd0);
    check("async_byte", 32'(bout), 32'd0);
    check("async_cnt", 32'(cnt), 32'd0);
    check("async_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0; mfi = 0; exp_q.delete();
    base = got.size();
    push(24'h5A5A00);
    model_push(24'h5A5A00);
    expect_stream(base, 1000);

    // Disabled input: strobes ignored, buffered samples still drain.
    do_reset();
    hold_busy = 1'b1;
    base = got.size();
    for (int k = 0; k < 3; k++) begin
      push(24'(24'h204060 + k * 24'h111100));
      model_push(24'(24'h204060 + k * 24'h111100));
    end
    enable = 1'b0;
    for (int k = 0; k < 5; k++) push(24'h777700);
    check("dis_cnt", 32'(cnt), 32'd3);
    hold_busy = 1'b0;
    expect_stream(base, 1500);
    for (int k = 0; k < 4; k++) push(24'h666600);
    settle(300);
    check("dis_no_tx", 32'(got.size() - base), 32'd7);
    check("dis_cnt_end", 32'(cnt), 32'd0);
    enable = 1'b1;

    // Randomized traffic with a fast, variable-latency transmitter.
    do_reset();
    rand_mode = 1'b1;
    base = got.size();
    pushed = 0; started = 0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      while (started < pushed && (2 * started + started / FLEN + 1) < (got.size() - base))
        started++;
      valid = 1'b0;
      enable = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0 && (!enable || (pushed - started) < DEPTH)) begin
        sample = SW'($urandom());
        valid = 1'b1;
        if (enable) begin
          model_push(sample);
          pushed++;
        end
      end
    end
    @(negedge clk);
    valid = 1'b0; enable = 1'b1;
    expect_stream(base, 6000);
    check("rand_ovf", 32'(ovf), 32'd0);
    rand_mode = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
